// File: rtl/cam_avg_sched.sv
// cam_avg_sched: frame-rate scheduler for the camera brightness-average path.
// Detects the V_SYNC falling edge, gates pixel accumulation, decimates frames
// and runs a serial restoring divider (one quotient bit per VGA_CLK). The
// frame average is published over a valid/ready handshake.
//
// Ports:
//   VGA_CLK    pixel clock, all logic on posedge
//   RST_N      synchronous active-low reset
//   V_SYNC     frame sync, high = active frame, falling edge = frame end
//   pix_valid  pixel qualifier
//   pixel      8-bit luminance
//   frame_div  publish one result every frame_div+1 frames (sampled at frame end)
//   avg_ready  consumer accepts avg_out
//   avg_out    frame average, stable while avg_valid
//   avg_valid  result pending
//   busy       divider running
//   overrun    sticky, a snapshot was dropped because the result path was busy
//
// Build option: define CAM_AVG_ROUND_EN for round-to-nearest (dividend is
// acc + cnt/2, saturating); otherwise the average is truncated.
//
// state  | meaning
// IDLE   | waiting for a frame snapshot
// DIVIDE | restoring divide in progress, ACC_W cycles
// HOLD   | avg_out valid, waiting for avg_ready
module cam_avg_sched #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 20
) (
    input  logic       VGA_CLK,
    input  logic       RST_N,
    input  logic       V_SYNC,
    input  logic       pix_valid,
    input  logic [7:0] pixel,
    input  logic [7:0] frame_div,
    input  logic       avg_ready,
    output logic [7:0] avg_out,
    output logic       avg_valid,
    output logic       busy,
    output logic       overrun
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIVIDE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam int IT_W  = $clog2(ACC_W);
    localparam int SUM_W = ACC_W + 1;

    logic [1:0]       state;
    logic             vs_d;
    logic             armed;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       dec_cnt;
    logic [ACC_W-1:0] dvd;        // dividend shifts out MSB first, quotient shifts in at LSB
    logic [ACC_W-1:0] rem;
    logic [CNT_W-1:0] divisor;
    logic [IT_W-1:0]  bit_cnt;

    logic             frame_end;
    logic             snap;
    logic [SUM_W-1:0] acc_sum;
    logic [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [ACC_W-1:0] dividend;
    logic [SUM_W-1:0] rem_sh;
    logic [SUM_W-1:0] rem_sub;
    logic             q_bit;
    logic [ACC_W-1:0] quot;

    assign frame_end = vs_d & ~V_SYNC;
    assign snap      = frame_end & armed & (dec_cnt == frame_div);

    assign acc_sum = {1'b0, acc} + SUM_W'(pixel);
    assign acc_nxt = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    assign cnt_nxt = (&cnt) ? cnt : cnt + CNT_W'(1);

`ifdef CAM_AVG_ROUND_EN
    logic [SUM_W-1:0] rnd_sum;
    assign rnd_sum  = {1'b0, acc} + SUM_W'(cnt >> 1);
    assign dividend = rnd_sum[ACC_W] ? '1 : rnd_sum[ACC_W-1:0];
`else
    assign dividend = acc;
`endif

    // The partial remainder stays below the divisor (< 2^CNT_W), so after the
    // shift it is far below 2^ACC_W and the top bit of the difference is a
    // reliable borrow flag.
    assign rem_sh  = {rem, dvd[ACC_W-1]};
    assign rem_sub = rem_sh - SUM_W'(divisor);
    assign q_bit   = ~rem_sub[ACC_W];
    assign quot    = {dvd[ACC_W-2:0], q_bit};

    assign avg_valid = (state == ST_HOLD);
    assign busy      = (state == ST_DIVIDE);

    always_ff @(posedge VGA_CLK) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            vs_d    <= 1'b0;
            armed   <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            dec_cnt <= '0;
            dvd     <= '0;
            rem     <= '0;
            divisor <= '0;
            bit_cnt <= '0;
            avg_out <= '0;
            overrun <= 1'b0;
        end else begin
            vs_d <= V_SYNC;

            // the first frame after reset is partial, so its end only arms
            if (frame_end) begin
                if (!armed) begin
                    armed <= 1'b1;
                end else begin
                    acc     <= '0;
                    cnt     <= '0;
                    dec_cnt <= (dec_cnt == frame_div) ? 8'd0 : dec_cnt + 8'd1;
                end
            end else if (armed && V_SYNC && pix_valid) begin
                acc <= acc_nxt;
                cnt <= cnt_nxt;
            end

            if (snap && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (snap) begin
                        if (cnt == '0) begin
                            state   <= ST_HOLD;
                            avg_out <= 8'd0;
                        end else begin
                            state   <= ST_DIVIDE;
                            dvd     <= dividend;
                            rem     <= '0;
                            divisor <= cnt;
                            bit_cnt <= IT_W'(ACC_W - 1);
                        end
                    end
                end
                ST_DIVIDE: begin
                    rem <= q_bit ? rem_sub[ACC_W-1:0] : rem_sh[ACC_W-1:0];
                    dvd <= quot;
                    if (bit_cnt == '0) begin
                        state   <= ST_HOLD;
                        avg_out <= (|quot[ACC_W-1:8]) ? 8'hFF : quot[7:0];
                    end else begin
                        bit_cnt <= bit_cnt - IT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (avg_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_avg_sched.sv
// Testbench for cam_avg_sched: table-driven frames with a result scoreboard,
// plus hand-written sequences for arming, back-pressure/overrun, decimation
// and reset during a divide.
module tb_cam_avg_sched;

    localparam int ACC_W = 32;
    localparam int CNT_W = 20;
    localparam int DIV_LAT = ACC_W + 1;

    logic       VGA_CLK;
    logic       RST_N;
    logic       V_SYNC;
    logic       pix_valid;
    logic [7:0] pixel;
    logic [7:0] frame_div;
    logic       avg_ready;
    logic [7:0] avg_out;
    logic       avg_valid;
    logic       busy;
    logic       overrun;

    cam_avg_sched #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .VGA_CLK   (VGA_CLK),
        .RST_N     (RST_N),
        .V_SYNC    (V_SYNC),
        .pix_valid (pix_valid),
        .pixel     (pixel),
        .frame_div (frame_div),
        .avg_ready (avg_ready),
        .avg_out   (avg_out),
        .avg_valid (avg_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial begin
        VGA_CLK = 1'b0;
        forever #5 VGA_CLK = ~VGA_CLK;
    end

    typedef struct {
        int         base;
        int         step;
        int         n;
        logic [7:0] exp_fl;
        logic [7:0] exp_rn;
    } vec_t;

    vec_t       vecs[9];
    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_results = 0;
    int         valid_cycles = 0;
    bit         busy_seen = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // scoreboard: every accepted result is compared with the oldest expectation
    always @(negedge VGA_CLK) begin
        if (busy) busy_seen = 1'b1;
        if (avg_valid) valid_cycles++;
        if (RST_N && avg_valid && avg_ready) begin
            n_results++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got %0d, expected no result", avg_out);
            end else begin
                check("avg_out", avg_out, exp_q.pop_front());
            end
        end
    end

    task automatic tick;
        @(posedge VGA_CLK);
        #1;
    endtask

    // Active frame with invalid gap cycles, then V_SYNC low with a garbage
    // valid pixel. Returns at the start of the frame_end cycle.
    task automatic drive_frame(input int base, input int step, input int n);
        tick;
        V_SYNC = 1'b1; pix_valid = 1'b0; pixel = 8'hAA;
        tick;
        tick;
        for (int i = 0; i < n; i++) begin
            if (i % 4 == 3) begin
                pix_valid = 1'b0; pixel = 8'h55;
                tick;
            end
            pix_valid = 1'b1; pixel = 8'(base + i * step);
            tick;
        end
        pix_valid = 1'b0;
        tick;
        V_SYNC = 1'b0; pix_valid = 1'b1; pixel = 8'hFF;
    endtask

    // cycles from frame_end cycle to first avg_valid, bounded
    task automatic wait_valid(output int lat);
        lat = 0;
        @(negedge VGA_CLK);
        while (!avg_valid && lat < 200) begin
            @(negedge VGA_CLK);
            lat++;
        end
    endtask

    logic [7:0] e;
    int         lat;
    int         base_cnt;

    initial begin
        vecs[0] = '{200, 0, 100, 8'd200, 8'd200};
        vecs[1] = '{0,   1, 100, 8'd49,  8'd50};
        vecs[2] = '{10,  0, 7,   8'd10,  8'd10};
        vecs[3] = '{255, 0, 300, 8'd255, 8'd255};
        vecs[4] = '{1,   2, 4,   8'd4,   8'd4};
        vecs[5] = '{0,   3, 3,   8'd3,   8'd3};
        vecs[6] = '{100, 1, 2,   8'd100, 8'd101};
        vecs[7] = '{0,   0, 0,   8'd0,   8'd0};
        vecs[8] = '{7,   5, 10,  8'd29,  8'd30};

        RST_N = 1'b0; V_SYNC = 1'b0; pix_valid = 1'b0; pixel = 8'd0;
        frame_div = 8'd0; avg_ready = 1'b0;
        repeat (5) tick;
        @(negedge VGA_CLK);
        check("rst_avg_out", avg_out, 0);
        check("rst_avg_valid", avg_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);

        // first frame only arms
        tick;
        RST_N = 1'b1;
        V_SYNC = 1'b1; pix_valid = 1'b1; pixel = 8'd50;
        repeat (10) tick;
        V_SYNC = 1'b0;
        base_cnt = valid_cycles;
        busy_seen = 1'b0;
        repeat (64) tick;
        check("arm_no_valid", valid_cycles - base_cnt, 0);
        check("arm_no_busy", busy_seen, 0);

        // table-driven frames, one result per frame, ready held high
        avg_ready = 1'b1;
        for (int v = 0; v < 9; v++) begin
`ifdef CAM_AVG_ROUND_EN
            e = vecs[v].exp_rn;
`else
            e = vecs[v].exp_fl;
`endif
            drive_frame(vecs[v].base, vecs[v].step, vecs[v].n);
            exp_q.push_back(e);
            busy_seen = 1'b0;
            wait_valid(lat);
            check($sformatf("latency_v%0d", v), lat, (vecs[v].n == 0) ? 1 : DIV_LAT);
            check($sformatf("busy_seen_v%0d", v), busy_seen, (vecs[v].n == 0) ? 0 : 1);
            @(negedge VGA_CLK);
            check($sformatf("one_cycle_valid_v%0d", v), avg_valid, 0);
        end
        check("overrun_clear", overrun, 0);

        // back-pressure: second published frame is dropped
        avg_ready = 1'b0;
        drive_frame(200, 0, 20);
        exp_q.push_back(8'd200);
        wait_valid(lat);
        check("bp_latency", lat, DIV_LAT);
        drive_frame(10, 0, 20);
        repeat (3) tick;
        @(negedge VGA_CLK);
        check("bp_overrun", overrun, 1);
        check("bp_valid_held", avg_valid, 1);
        check("bp_avg_held", avg_out, 200);
        tick;
        avg_ready = 1'b1;
        tick;
        @(negedge VGA_CLK);
        check("bp_valid_drop", avg_valid, 0);

        // decimation: frame_div=2 publishes frames 3 and 6
        frame_div = 8'd2;
        base_cnt = n_results;
        for (int f = 0; f < 6; f++) begin
            drive_frame(20 + 10 * f, 0, 5);
            if (f == 2 || f == 5) exp_q.push_back(8'(20 + 10 * f));
            repeat (45) tick;
        end
        check("decim_results", n_results - base_cnt, 2);

        // reset in the middle of a divide
        frame_div = 8'd0;
        drive_frame(123, 0, 10);
        repeat (9) tick;
        @(negedge VGA_CLK);
        check("mid_busy", busy, 1);
        tick;
        RST_N = 1'b0;
        tick;
        tick;
        @(negedge VGA_CLK);
        check("mrst_busy", busy, 0);
        check("mrst_valid", avg_valid, 0);
        check("mrst_overrun", overrun, 0);
        check("mrst_avg_out", avg_out, 0);
        tick;
        RST_N = 1'b1;
        base_cnt = valid_cycles;
        repeat (60) tick;
        check("mrst_no_result", valid_cycles - base_cnt, 0);

        // recovery: arm frame, then a real one
        drive_frame(0, 0, 3);
        repeat (40) tick;
        check("rearm_no_result", valid_cycles - base_cnt, 0);
        drive_frame(77, 0, 9);
        exp_q.push_back(8'd77);
        wait_valid(lat);
        check("rearm_latency", lat, DIV_LAT);
        repeat (3) tick;
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
